multi_channel_collector: RTL
============================

// Module: multi_channel_collector
// PURPOSE
//  Generalised NoC receive collector for the MLP tile. Accepts one AXI-S rx stream and steers each
//  packet by tid into one of NUM_CH per-channel data FIFOs. Packets are channel-locked at the
//  first beat until tlast. Out-of-range packets are accepted and dropped.
//  Sits between the NoC rx interface and NUM_CH independent MVM consumers.
// PARAMETERS
//  NUM_CH     4        number of output channels (>=1)
//  DATAW      512      payload bits stored per beat (tdata[DATAW-1:0])
//  USERW      75       axi-s tuser width
//  DATAUSERW  DATAW+USERW  axi-s tdata width
//  BYTEW      8        tstrb/tkeep width
//  IDW        32       tid width
//  DESTW      7        tdest width
//  DEPTH      512      entries per channel FIFO
//  CHW        $clog2(NUM_CH) (min 1), localparam, channel index width
// PORTS
//  clk             in   1               clock
//  rst             in   1               sync reset, active-high
//  axis_rx_tvalid  in   1               rx beat valid
//  axis_rx_tdata   in   DATAUSERW       rx data; low DATAW bits stored
//  axis_rx_tstrb   in   BYTEW           unused, registered to noprune sink
//  axis_rx_tkeep   in   BYTEW           unused, registered to noprune sink
//  axis_rx_tid     in   IDW             destination channel of packet
//  axis_rx_tdest   in   DESTW           unused, registered to noprune sink
//  axis_rx_tuser   in   USERW           unused, registered to noprune sink
//  axis_rx_tlast   in   1               last beat of packet
//  axis_rx_tready  out  1               rx ready
//  ch_pop          in   NUM_CH          per-channel FIFO pop
//  ch_rdata        out  NUM_CH*DATAW    per-channel head data, ch c at [c*DATAW +: DATAW]
//  ch_rdy          out  NUM_CH          per-channel non-empty
//  drop_pulse      out  1               1-cycle pulse when a dropped packet's tlast is accepted
// BEHAVIOUR
//  - Reset: tready=0, ch_rdy=0, drop_pulse=0, FSM=IDLE, all FIFOs emptied, all counters 0.
//  - FSM states: IDLE, IN_PKT(lock_ch), DROP.
//    - Target channel: tid in IDLE, lock_ch otherwise.
//    - tid >= NUM_CH, including any nonzero upper bits, is out of range.
//  - IDLE, in-range tid:
//    - tready = ~almost_full[tid].
//    - On accept: push to FIFO[tid]; !tlast -> IN_PKT with lock_ch=tid; tlast -> stay IDLE.
//  - IDLE, out-of-range tid:
//    - tready=1; beat discarded.
//    - !tlast -> DROP; tlast -> drop_pulse next cycle, stay IDLE.
//  - IN_PKT:
//    - tid ignored; tready = ~almost_full[lock_ch].
//    - Accepted beats push to FIFO[lock_ch]; accepted tlast -> IDLE.
//  - DROP:
//    - tready=1; beats discarded.
//    - Accepted tlast -> IDLE with drop_pulse the following cycle.
//  - tready is combinational from FSM state, tid and almost_full. No tvalid->tready dependency.
//  - Push latency: accepted beat visible at ch_rdata/ch_rdy one cycle after acceptance.
//  - FIFO is show-ahead: ch_rdata valid whenever ch_rdy=1. ch_pop advances head next cycle.
//    ch_pop while empty is ignored.
//  - Simultaneous push and pop on one channel: both take effect, occupancy unchanged.
//  - A full or almost-full channel stalls only its own packets; other channels keep draining.
//    Head-of-line blocking on the single rx stream is accepted.
//  - Reset mid-packet: FSM -> IDLE, partial packet in FIFO discarded. The next beat is treated
//    as a first beat.
// CONFIGURATION
//  COLLECTOR_STATS_EN defined: adds the following ports.
//  - ch_beats   out NUM_CH*32  accepted beats per channel.
//  - ch_frames  out NUM_CH*32  accepted tlast per channel.
//  - drop_count out 32         dropped packets.
//  - All counters are 32-bit, wrap at 2^32, cleared by rst, and update the cycle after the event.
//  COLLECTOR_STATS_EN undefined: these ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  - Package mlp_collector_pkg:
//    - collector_state_e enum (IDLE, IN_PKT, DROP).
//    - STAT_W=32.
//    - Function ch_in_range(tid, NUM_CH).
//  - Sub-module collector_channel (x NUM_CH):
//    - Wraps the existing fifo (push, idata, pop, odata, empty, full, almost_full).
//    - Holds the per-channel stats counters under COLLECTOR_STATS_EN.
//  - Top level contains the FSM, tready mux, push decode and noprune sinks.
// TESTING
//  1. Single 3-beat packet, tid=2, data 0xA,0xB,0xC -> only ch_rdy[2]=1.
//     Pop order A,B,C; ch_beats[2]=3, ch_frames[2]=1.
//  2. Packet tid=1 where beat 2 carries tid=3 -> all beats land in ch 1 (lock); ch 3 stays empty.
//  3. Packet tid=7 (NUM_CH=4), 4 beats -> tready=1 throughout, no FIFO push.
//     One drop_pulse after tlast; drop_count=1.
//  4. Fill ch 0 to almost_full, then offer tid=0 -> tready=0.
//     Offer tid=2 -> tready=1, beat accepted. Pop ch 0 -> tready for tid=0 returns to 1.
//  5. Steady push and pop on ch 3 in the same cycles for 100 beats -> occupancy constant, data in order.
//  6. Assert rst after beat 2 of a 4-beat tid=1 packet -> FIFOs empty, FSM IDLE.
//     Next beat with tid=0 lands in ch 0.

Source files
------------

// File: rtl/multi_channel_collector_pkg.sv
// rtl/multi_channel_collector_pkg.sv - shared state type, stats width and tid range helper for the collector
package mlp_collector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } collector_state_e;

    localparam int STAT_W    = 32;
    localparam int TID_MAX_W = 64;

    // Any nonzero upper tid bit makes the packet out of range, so compare the full value.
    function automatic logic ch_in_range(input logic [TID_MAX_W-1:0] tid, input int unsigned num_ch);
        return tid < TID_MAX_W'(num_ch);
    endfunction

endpackage

// File: rtl/multi_channel_collector_if.sv
// rtl/multi_channel_collector_if.sv - rx stream and per-channel drain signals of the collector
interface multi_channel_collector_if #(
    parameter int NUM_CH = 4,
    parameter int DATAW  = 512,
    parameter int USERW  = 75,
    parameter int BYTEW  = 8,
    parameter int IDW    = 32,
    parameter int DESTW  = 7
);
    localparam int DATAUSERW = DATAW + USERW;

    logic                    axis_rx_tvalid;
    logic [DATAUSERW-1:0]    axis_rx_tdata;
    logic [BYTEW-1:0]        axis_rx_tstrb;
    logic [BYTEW-1:0]        axis_rx_tkeep;
    logic [IDW-1:0]          axis_rx_tid;
    logic [DESTW-1:0]        axis_rx_tdest;
    logic [USERW-1:0]        axis_rx_tuser;
    logic                    axis_rx_tlast;
    logic                    axis_rx_tready;
    logic [NUM_CH-1:0]       ch_pop;
    logic [NUM_CH*DATAW-1:0] ch_rdata;
    logic [NUM_CH-1:0]       ch_rdy;
    logic                    drop_pulse;

    modport master (
        output axis_rx_tvalid, axis_rx_tdata, axis_rx_tstrb, axis_rx_tkeep, axis_rx_tid,
               axis_rx_tdest, axis_rx_tuser, axis_rx_tlast, ch_pop,
        input  axis_rx_tready, ch_rdata, ch_rdy, drop_pulse
    );

    modport slave (
        input  axis_rx_tvalid, axis_rx_tdata, axis_rx_tstrb, axis_rx_tkeep, axis_rx_tid,
               axis_rx_tdest, axis_rx_tuser, axis_rx_tlast, ch_pop,
        output axis_rx_tready, ch_rdata, ch_rdy, drop_pulse
    );
endinterface

// File: rtl/fifo.sv
// rtl/fifo.sv - show-ahead synchronous FIFO with full and almost-full flags (DEPTH >= 2)
module fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] idata,
    input  logic             pop,
    output logic [WIDTH-1:0] odata,
    output logic             empty,
    output logic             full,
    output logic             almost_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_inc(wptr);
            if (do_pop)  rptr <= ptr_inc(rptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= idata;
    end

    assign odata       = mem[rptr];
    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(DEPTH - 1));
endmodule

// File: rtl/multi_channel_collector_channel.sv
// rtl/multi_channel_collector_channel.sv - one output channel: data FIFO plus COLLECTOR_STATS_EN counters
module collector_channel
    import mlp_collector_pkg::*;
#(
    parameter int DATAW = 512,
    parameter int DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATAW-1:0]  idata,
    input  logic              pop,
    output logic [DATAW-1:0]  odata,
    output logic              rdy,
    output logic              almost_full
`ifdef COLLECTOR_STATS_EN
    ,
    input  logic              push_last,
    output logic [STAT_W-1:0] beats,
    output logic [STAT_W-1:0] frames
`endif
);
    logic empty;
    logic full_unused;

    fifo #(.WIDTH(DATAW), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .idata       (idata),
        .pop         (pop),
        .odata       (odata),
        .empty       (empty),
        .full        (full_unused),
        .almost_full (almost_full)
    );

    assign rdy = ~empty;

`ifdef COLLECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beats  <= '0;
            frames <= '0;
        end else if (push) begin
            beats <= beats + 1'b1;
            if (push_last) frames <= frames + 1'b1;
        end
    end
`endif
endmodule

// File: rtl/multi_channel_collector.sv
// rtl/multi_channel_collector.sv - steers rx packets by tid into NUM_CH FIFOs; COLLECTOR_STATS_EN adds counters
module multi_channel_collector
    import mlp_collector_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATAW  = 512,
    parameter int USERW  = 75,
    parameter int BYTEW  = 8,
    parameter int IDW    = 32,
    parameter int DESTW  = 7,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_channel_collector_if.slave bus
`ifdef COLLECTOR_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0] ch_beats,
    output logic [NUM_CH*STAT_W-1:0] ch_frames,
    output logic [STAT_W-1:0]        drop_count
`endif
);
    localparam int DATAUSERW = DATAW + USERW;
    localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SINKW     = USERW + 2 * BYTEW + DESTW + USERW;

    collector_state_e  state, state_nxt;
    logic [CHW-1:0]    lock_ch, lock_ch_nxt, tgt_ch;
    logic              tid_ok, tready, drop_nxt, drop_q;
    logic [NUM_CH-1:0] af, push;

    assign tid_ok = ch_in_range(TID_MAX_W'(bus.axis_rx_tid), NUM_CH);
    assign tgt_ch = (state == IDLE) ? bus.axis_rx_tid[CHW-1:0] : lock_ch;

    always_comb begin
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        tready      = 1'b0;
        push        = '0;
        drop_nxt    = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    tready = tid_ok ? ~af[tgt_ch] : 1'b1;
                    if (bus.axis_rx_tvalid && tready) begin
                        if (tid_ok) begin
                            push[tgt_ch] = 1'b1;
                            if (!bus.axis_rx_tlast) begin
                                state_nxt   = IN_PKT;
                                lock_ch_nxt = tgt_ch;
                            end
                        end else if (bus.axis_rx_tlast) begin
                            drop_nxt = 1'b1;
                        end else begin
                            state_nxt = DROP;
                        end
                    end
                end
                IN_PKT: begin
                    tready = ~af[lock_ch];
                    if (bus.axis_rx_tvalid && tready) begin
                        push[lock_ch] = 1'b1;
                        if (bus.axis_rx_tlast) state_nxt = IDLE;
                    end
                end
                DROP: begin
                    tready = 1'b1;
                    if (bus.axis_rx_tvalid && bus.axis_rx_tlast) begin
                        state_nxt = IDLE;
                        drop_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
            drop_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
            drop_q  <= drop_nxt;
        end
    end

    assign bus.axis_rx_tready = tready;
    assign bus.drop_pulse     = drop_q;

`ifdef COLLECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)           drop_count <= '0;
        else if (drop_nxt) drop_count <= drop_count + 1'b1;
    end
`endif

    // Sideband fields are kept alive in a register so the rx interface survives synthesis intact.
    (* noprune *) logic [SINKW-1:0] sink_unused_q;
    always_ff @(posedge clk) begin
        sink_unused_q <= {bus.axis_rx_tdata[DATAUSERW-1:DATAW], bus.axis_rx_tstrb,
                          bus.axis_rx_tkeep, bus.axis_rx_tdest, bus.axis_rx_tuser};
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        collector_channel #(.DATAW(DATAW), .DEPTH(DEPTH)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .push        (push[c]),
            .idata       (bus.axis_rx_tdata[DATAW-1:0]),
            .pop         (bus.ch_pop[c]),
            .odata       (bus.ch_rdata[c*DATAW +: DATAW]),
            .rdy         (bus.ch_rdy[c]),
            .almost_full (af[c])
`ifdef COLLECTOR_STATS_EN
            ,
            .push_last   (bus.axis_rx_tlast),
            .beats       (ch_beats[c*STAT_W +: STAT_W]),
            .frames      (ch_frames[c*STAT_W +: STAT_W])
`endif
        );
    end
endmodule
